// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TileLink-UH manager endpoint backed by a DEPTH_WORDS x 64-bit RAM.
// Accepts Get, PutFullData, PutPartialData and Hint on A and answers on D with one
// transaction in flight. Bursts advance one 64-bit word per beat and wrap within the RAM.
// Optional feature macro: TL_RAM_STRICT_ALIGN_EN -- when defined, requests whose address
// is not aligned to their size are denied. When undefined, the low address bits below
// the size are ignored and the burst starts at the aligned-down address.
module tl_ram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 512,
  parameter int          MAX_SIZE    = 6,
  parameter logic [2:0]  SINK_ID     = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [2:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_source,
  output logic [2:0]  auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Beat counter wide enough for the largest encodable size (2^15 bytes = 4096 beats).
  localparam int CW = 12;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGIC       = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PUT,
    S_ACK,
    S_GET
  } state_t;

  state_t state, state_next;

  logic [63:0] ram [DEPTH_WORDS];

  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] last_q;
  logic [AW-1:0] req_idx_q;
  logic [3:0]    req_size_q;
  logic [2:0]    req_source_q;
  logic          req_denied_q;

  logic          d_valid_q;
  logic [2:0]    d_opcode_q;
  logic [3:0]    d_size_q;
  logic [2:0]    d_source_q;
  logic          d_denied_q;
  logic [63:0]   d_data_q;
  logic          d_corrupt_q;

  logic [32:0]   size_bytes;
  logic [32:0]   end_addr;
  logic [31:0]   size_mask;
  logic [31:0]   start_addr;
  logic [31:0]   offset;
  logic [12:0]   beats_full;
  logic [CW-1:0] dec_last;
  logic [AW-1:0] dec_idx;
  logic          bad_opcode;
  logic          misaligned;
  logic          dec_denied;

  logic          a_fire;
  logic          d_fire;
  logic          cap_en;
  logic          wr_en;
  logic          wr_full;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [63:0]   rd_data;
  logic          d_load;
  logic          d_drop;
  logic [2:0]    ld_opcode;
  logic [3:0]    ld_size;
  logic [2:0]    ld_source;
  logic          ld_denied;
  logic          ld_read;

  logic          unused_bits;

  // Only IDLE and PUT consume A beats; held off while reset is asserted.
  assign auto_in_a_ready = reset & ((state == S_IDLE) | (state == S_PUT));
  assign a_fire          = auto_in_a_valid & auto_in_a_ready;
  assign d_fire          = d_valid_q & auto_in_d_ready;
  assign rd_data         = ram[rd_idx];

  assign auto_in_d_valid        = d_valid_q;
  assign auto_in_d_bits_opcode  = d_opcode_q;
  assign auto_in_d_bits_param   = 2'd0;
  assign auto_in_d_bits_size    = d_size_q;
  assign auto_in_d_bits_source  = d_source_q;
  assign auto_in_d_bits_sink    = SINK_ID;
  assign auto_in_d_bits_denied  = d_denied_q;
  assign auto_in_d_bits_data    = d_data_q;
  assign auto_in_d_bits_corrupt = d_corrupt_q;

  assign unused_bits = ^{auto_in_a_bits_param, offset[2:0], offset[31:AW+3], size_mask};

  // Decode the incoming first A beat: burst length, start word and whether it is refused.
  always_comb begin
    size_bytes = 33'd1 << auto_in_a_bits_size;
    end_addr   = {1'b0, auto_in_a_bits_address} + size_bytes - 33'd1;
    size_mask  = 32'(size_bytes - 33'd1);
    // Arith (2), Logic (3) and the undefined codes 6/7 all have bit 1 set.
    bad_opcode = auto_in_a_bits_opcode[1];
`ifdef TL_RAM_STRICT_ALIGN_EN
    misaligned = |(auto_in_a_bits_address[MAX_SIZE-1:0] & size_mask[MAX_SIZE-1:0]);
    start_addr = auto_in_a_bits_address;
`else
    misaligned = 1'b0;
    start_addr = auto_in_a_bits_address & ~size_mask;
`endif
    offset  = start_addr - BASE_ADDR;
    dec_idx = offset[AW+2:3];
    if (auto_in_a_bits_size <= 4'd3) begin
      beats_full = 13'd1;
    end else begin
      beats_full = 13'd1 << (auto_in_a_bits_size - 4'd3);
    end
    dec_last   = CW'(beats_full - 13'd1);
    dec_denied = (auto_in_a_bits_address < BASE_ADDR) | (end_addr >= LIMIT) |
                 (auto_in_a_bits_size > 4'(MAX_SIZE)) | bad_opcode | misaligned;
  end

  // Next-state logic plus the RAM write/read strobes and the D-register load request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cap_en     = 1'b0;
    wr_en      = 1'b0;
    wr_full    = (auto_in_a_bits_opcode == A_PUT_FULL);
    wr_idx     = dec_idx;
    rd_idx     = dec_idx;
    d_load     = 1'b0;
    d_drop     = 1'b0;
    ld_opcode  = D_ACK;
    ld_size    = req_size_q;
    ld_source  = req_source_q;
    ld_denied  = req_denied_q;
    ld_read    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (a_fire) begin
          cap_en    = 1'b1;
          cnt_next  = '0;
          ld_size   = auto_in_a_bits_size;
          ld_source = auto_in_a_bits_source;
          ld_denied = dec_denied;
          case (auto_in_a_bits_opcode)
            A_PUT_FULL, A_PUT_PARTIAL: begin
              wr_en = ~dec_denied;
              if (dec_last == '0) begin
                state_next = S_ACK;
                d_load     = 1'b1;
              end else begin
                state_next = S_PUT;
                cnt_next   = CW'(1);
              end
            end
            A_GET, A_ARITH, A_LOGIC: begin
              state_next = S_GET;
              d_load     = 1'b1;
              ld_opcode  = D_ACK_DATA;
              ld_read    = 1'b1;
            end
            A_HINT: begin
              state_next = S_ACK;
              d_load     = 1'b1;
              ld_opcode  = D_HINT_ACK;
            end
            default: begin
              state_next = S_ACK;
              d_load     = 1'b1;
            end
          endcase
        end
      end
      S_PUT: begin
        if (a_fire) begin
          wr_en  = ~req_denied_q;
          wr_idx = req_idx_q + AW'(cnt);
          if (cnt == last_q) begin
            state_next = S_ACK;
            d_load     = 1'b1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      S_ACK: begin
        if (d_fire) begin
          d_drop     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_GET: begin
        if (d_fire) begin
          if (cnt == last_q) begin
            d_drop     = 1'b1;
            state_next = S_IDLE;
          end else begin
            cnt_next  = cnt + CW'(1);
            d_load    = 1'b1;
            ld_opcode = D_ACK_DATA;
            ld_read   = 1'b1;
            rd_idx    = req_idx_q + AW'(cnt + CW'(1));
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, beat counter and the per-transaction fields captured from the first A beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_q       <= '0;
      req_idx_q    <= '0;
      req_size_q   <= '0;
      req_source_q <= '0;
      req_denied_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (cap_en) begin
        last_q       <= dec_last;
        req_idx_q    <= dec_idx;
        req_size_q   <= auto_in_a_bits_size;
        req_source_q <= auto_in_a_bits_source;
        req_denied_q <= dec_denied;
      end
    end
  end

  // Registered D channel: loaded when a beat is produced, held until it is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_valid_q   <= 1'b0;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
      d_corrupt_q <= 1'b0;
    end else if (d_load) begin
      d_valid_q   <= 1'b1;
      d_opcode_q  <= ld_opcode;
      d_size_q    <= ld_size;
      d_source_q  <= ld_source;
      d_denied_q  <= ld_denied;
      d_data_q    <= (ld_read & ~ld_denied) ? rd_data : 64'd0;
      d_corrupt_q <= ld_read & ld_denied;
    end else if (d_drop) begin
      d_valid_q <= 1'b0;
    end
  end

  // Byte-lane RAM write; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (wr_full | auto_in_a_bits_mask[i]) begin
          ram[wr_idx][8*i +: 8] <= auto_in_a_bits_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_ram_responder.sv
// Testbench for tl_ram_responder: directed scenarios plus randomized traffic, each
// checked against a word-array memory model and the access rules of the endpoint.
module tb_tl_ram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 512;
  localparam int          MAXS  = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [3:0]  a_size = '0;
  logic [2:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [2:0]  d_source;
  logic [2:0]  d_sink;
  logic        d_denied;
  logic [63:0] d_data;
  logic        d_corrupt;

  always #5 clock = ~clock;

  tl_ram_responder dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_param   (a_param),
    .auto_in_a_bits_size    (a_size),
    .auto_in_a_bits_source  (a_source),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_param   (d_param),
    .auto_in_d_bits_size    (d_size),
    .auto_in_d_bits_source  (d_source),
    .auto_in_d_bits_sink    (d_sink),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model_mem [DEPTH];

  logic [63:0] tx_data [$];
  logic [7:0]  tx_mask [$];

  logic [2:0]  rx_op   [$];
  logic [63:0] rx_data [$];
  logic        rx_den  [$];
  logic        rx_cor  [$];
  logic [3:0]  rx_size [$];
  logic [2:0]  rx_src  [$];
  int          first_wait;
  int          stall_changes;

  // Reference rules: beat count, refusal and start word, in plain arithmetic.
  function automatic int m_beats(input int size);
    return (size <= 3) ? 1 : (1 << (size - 3));
  endfunction

  function automatic bit m_denied(input int op, input int size, input logic [31:0] addr);
    longint a;
    longint lo;
    longint hi;
    a  = addr;
    lo = BASE;
    hi = lo + 8 * DEPTH;
    if (a < lo) return 1'b1;
    if (a + (longint'(1) << size) - 1 >= hi) return 1'b1;
    if (size > MAXS) return 1'b1;
    if (op == 2 || op == 3 || op == 6 || op == 7) return 1'b1;
`ifdef TL_RAM_STRICT_ALIGN_EN
    if ((a % (longint'(1) << size)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_word(input int size, input logic [31:0] addr);
    longint a;
    longint b;
    a = addr;
    b = BASE;
    a = a - (a % (longint'(1) << size));
    return int'(((a - b) / 8) % DEPTH);
  endfunction

  function automatic void m_put(input int op, input int size, input logic [31:0] addr);
    int w;
    logic [7:0] m;
    if (m_denied(op, size, addr)) return;
    w = m_word(size, addr);
    for (int b = 0; b < m_beats(size); b++) begin
      m = tx_mask[b];
      for (int l = 0; l < 8; l++) begin
        if (op == 0 || m[l]) model_mem[(w + b) % DEPTH][8*l +: 8] = tx_data[b][8*l +: 8];
      end
    end
  endfunction

  // Drive one request on A (all beats for a Put), bounded wait on a_ready.
  task automatic send_req(input int op, input int size, input int src, input logic [31:0] addr);
    int nb;
    int t;
    nb = (op <= 1) ? m_beats(size) : 1;
    for (int b = 0; b < nb; b++) begin
      @(negedge clock);
      a_valid   = 1'b1;
      a_opcode  = 3'(op);
      a_size    = 4'(size);
      a_source  = 3'(src);
      a_address = addr;
      a_param   = 3'($urandom_range(0, 7));
      a_mask    = (b < tx_mask.size()) ? tx_mask[b] : 8'hFF;
      a_data    = (b < tx_data.size()) ? tx_data[b] : 64'd0;
      t = 0;
      while (!a_ready && t < 200) begin
        @(negedge clock);
        t++;
      end
      if (!a_ready) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL a_ready_timeout: beat %0d never accepted, required a_ready=1", b);
        a_valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
      a_valid = 1'b0;
    end
  endtask

  // Gather n D beats. mode 0: always ready, 1: toggling ready, 2: random ready.
  task automatic collect(input int n, input int mode);
    int t;
    int got;
    bit have;
    logic [75:0] snap;
    logic [75:0] cur;
    rx_op.delete(); rx_data.delete(); rx_den.delete();
    rx_cor.delete(); rx_size.delete(); rx_src.delete();
    got = 0; t = 0; have = 1'b0; first_wait = -1; stall_changes = 0; snap = '0;
    while (got < n && t < 4000) begin
      @(negedge clock);
      t++;
      if (mode == 1)      d_ready = (t % 2 == 0);
      else if (mode == 2) d_ready = 1'($urandom_range(0, 1));
      else                d_ready = 1'b1;
      if (d_valid) begin
        cur = {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
        if (first_wait < 0) first_wait = t - 1;
        if (have && cur !== snap) stall_changes++;
        if (d_ready) begin
          rx_op.push_back(d_opcode);  rx_data.push_back(d_data);
          rx_den.push_back(d_denied); rx_cor.push_back(d_corrupt);
          rx_size.push_back(d_size);  rx_src.push_back(d_source);
          got++;
          have = 1'b0;
        end else begin
          snap = cur;
          have = 1'b1;
        end
      end
    end
    d_ready = 1'b1;
    if (got < n) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL d_beat_timeout: got %0d beats, required %0d", got, n);
    end
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (a_ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_a_ready: got %b required 0", a_ready); end
    n_cmp++;
    if (d_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_d_valid: got %b required 0", d_valid); end
    n_cmp++;
    if ({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_d_bits: got op=%0d data=%h den=%b cor=%b required all 0", d_opcode, d_data, d_denied, d_corrupt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_err++; $display("[TB] FAIL release_a_ready: got %b required 1", a_ready); end
  endtask

  // Write the whole RAM with random 8-beat bursts so every later read has a known value.
  task automatic test_fill;
    for (int blk = 0; blk < DEPTH / 8; blk++) begin
      tx_data.delete(); tx_mask.delete();
      for (int b = 0; b < 8; b++) begin
        tx_data.push_back({$urandom, $urandom});
        tx_mask.push_back(8'hFF);
      end
      send_req(0, 6, blk % 8, BASE + 32'(64 * blk));
      m_put(0, 6, BASE + 32'(64 * blk));
      collect(1, 0);
      n_cmp++;
      if (rx_op.size() != 1 || rx_op[0] !== 3'd0 || rx_den[0] !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL fill_ack: block %0d beats=%0d, required one AccessAck not denied", blk, rx_op.size());
      end
    end
  endtask

  task automatic test_basic;
    tx_data = '{64'h1122334455667788};
    tx_mask = '{8'hFF};
    send_req(0, 3, 1, BASE);
    m_put(0, 3, BASE);
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd0 || rx_den[0] !== 1'b0 || rx_src[0] !== 3'd1) begin
      n_err++; $display("[TB] FAIL put_ack: got op=%0d den=%b src=%0d required op=0 den=0 src=1", rx_op[0], rx_den[0], rx_src[0]);
    end
    n_cmp++;
    if (first_wait !== 0) begin n_err++; $display("[TB] FAIL put_latency: got %0d idle cycles required 0", first_wait); end
    tx_data.delete(); tx_mask.delete();
    send_req(4, 3, 2, BASE);
    collect(1, 0);
    n_cmp++;
    if (rx_data[0] !== 64'h1122334455667788) begin
      n_err++; $display("[TB] FAIL get_data: got %h required 1122334455667788", rx_data[0]);
    end
    n_cmp++;
    if (rx_op[0] !== 3'd1 || rx_den[0] !== 1'b0 || rx_cor[0] !== 1'b0 || rx_size[0] !== 4'd3 || rx_src[0] !== 3'd2) begin
      n_err++; $display("[TB] FAIL get_fields: got op=%0d den=%b cor=%b size=%0d src=%0d required 1/0/0/3/2",
                        rx_op[0], rx_den[0], rx_cor[0], rx_size[0], rx_src[0]);
    end
    n_cmp++;
    if (first_wait !== 0) begin n_err++; $display("[TB] FAIL get_latency: got %0d idle cycles required 0", first_wait); end
  endtask

  task automatic test_partial;
    tx_data = '{64'hFFFF_FFFF_FFFF_FFFF};
    tx_mask = '{8'h0F};
    send_req(1, 3, 3, BASE);
    m_put(1, 3, BASE);
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd0) begin n_err++; $display("[TB] FAIL partial_ack: got op=%0d required 0", rx_op[0]); end
    tx_data.delete(); tx_mask.delete();
    send_req(4, 3, 3, BASE);
    collect(1, 0);
    n_cmp++;
    if (rx_data[0] !== 64'h11223344FFFFFFFF) begin
      n_err++; $display("[TB] FAIL partial_data: got %h required 11223344ffffffff", rx_data[0]);
    end
  endtask

  task automatic test_burst;
    tx_data.delete(); tx_mask.delete();
    for (int b = 0; b < 8; b++) begin
      tx_data.push_back(64'(b));
      tx_mask.push_back(8'hFF);
    end
    send_req(0, 6, 5, BASE + 32'h40);
    m_put(0, 6, BASE + 32'h40);
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd0 || rx_size[0] !== 4'd6) begin
      n_err++; $display("[TB] FAIL burst_put_ack: got op=%0d size=%0d required 0/6", rx_op[0], rx_size[0]);
    end
    tx_data.delete(); tx_mask.delete();
    send_req(4, 6, 6, BASE + 32'h40);
    collect(8, 1);
    n_cmp++;
    if (rx_op.size() != 8) begin n_err++; $display("[TB] FAIL burst_beats: got %0d required 8", rx_op.size()); end
    for (int b = 0; b < rx_op.size(); b++) begin
      n_cmp++;
      if (rx_data[b] !== 64'(b) || rx_op[b] !== 3'd1 || rx_src[b] !== 3'd6 || rx_size[b] !== 4'd6 || rx_den[b] !== 1'b0) begin
        n_err++; $display("[TB] FAIL burst_beat%0d: got data=%h op=%0d src=%0d size=%0d required data=%0d op=1 src=6 size=6",
                          b, rx_data[b], rx_op[b], rx_src[b], rx_size[b], b);
      end
    end
    n_cmp++;
    if (stall_changes !== 0) begin n_err++; $display("[TB] FAIL burst_stall_stable: got %0d changes required 0", stall_changes); end
    @(negedge clock);
    n_cmp++;
    if (d_valid !== 1'b0) begin n_err++; $display("[TB] FAIL burst_extra_beat: got d_valid=%b required 0", d_valid); end
  endtask

  task automatic test_denied;
    int          ops   [4] = '{4, 4, 3, 2};
    int          sizes [4] = '{3, 3, 3, 4};
    logic [31:0] addrs [4];
    logic [63:0] keep;
    addrs = '{32'h7FFF_FFF8, BASE + 32'(8 * DEPTH), BASE, BASE};
    tx_data.delete(); tx_mask.delete();
    for (int k = 0; k < 4; k++) begin
      send_req(ops[k], sizes[k], k, addrs[k]);
      collect(m_beats(sizes[k]), 0);
      n_cmp++;
      if (rx_op.size() != m_beats(sizes[k])) begin
        n_err++; $display("[TB] FAIL denied_beats%0d: got %0d required %0d", k, rx_op.size(), m_beats(sizes[k]));
      end
      for (int b = 0; b < rx_op.size(); b++) begin
        n_cmp++;
        if (rx_op[b] !== 3'd1 || rx_den[b] !== 1'b1 || rx_cor[b] !== 1'b1 || rx_data[b] !== 64'd0) begin
          n_err++; $display("[TB] FAIL denied_get%0d: got op=%0d den=%b cor=%b data=%h required 1/1/1/0",
                            k, rx_op[b], rx_den[b], rx_cor[b], rx_data[b]);
        end
      end
    end
    send_req(6, 3, 0, BASE);
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd0 || rx_den[0] !== 1'b1 || rx_cor[0] !== 1'b0) begin
      n_err++; $display("[TB] FAIL denied_op6: got op=%0d den=%b cor=%b required 0/1/0", rx_op[0], rx_den[0], rx_cor[0]);
    end
    keep = model_mem[DEPTH - 1];
    tx_data = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0002};
    tx_mask = '{8'hFF, 8'hFF};
    send_req(0, 4, 0, BASE + 32'(8 * DEPTH - 8));
    m_put(0, 4, BASE + 32'(8 * DEPTH - 8));
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd0 || rx_den[0] !== 1'b1) begin
      n_err++; $display("[TB] FAIL denied_put_ack: got op=%0d den=%b required 0/1", rx_op[0], rx_den[0]);
    end
    tx_data.delete(); tx_mask.delete();
    send_req(4, 3, 1, BASE + 32'(8 * DEPTH - 8));
    collect(1, 0);
    n_cmp++;
    if (rx_data[0] !== keep || rx_den[0] !== 1'b0) begin
      n_err++; $display("[TB] FAIL denied_put_nowrite: got %h den=%b required %h den=0", rx_data[0], rx_den[0], keep);
    end
  endtask

  task automatic test_hint_oversize;
    tx_data.delete(); tx_mask.delete();
    send_req(5, 3, 4, BASE + 32'h8);
    collect(1, 0);
    n_cmp++;
    if (rx_op[0] !== 3'd2 || rx_den[0] !== 1'b0 || rx_data[0] !== 64'd0 || rx_src[0] !== 3'd4) begin
      n_err++; $display("[TB] FAIL hint_ack: got op=%0d den=%b data=%h src=%0d required 2/0/0/4", rx_op[0], rx_den[0], rx_data[0], rx_src[0]);
    end
    send_req(4, 7, 1, BASE);
    collect(16, 0);
    n_cmp++;
    if (rx_op.size() != 16) begin n_err++; $display("[TB] FAIL oversize_beats: got %0d required 16", rx_op.size()); end
    for (int b = 0; b < rx_op.size(); b++) begin
      n_cmp++;
      if (rx_op[b] !== 3'd1 || rx_den[b] !== 1'b1 || rx_cor[b] !== 1'b1 || rx_data[b] !== 64'd0 || rx_size[b] !== 4'd7) begin
        n_err++; $display("[TB] FAIL oversize_beat%0d: got op=%0d den=%b cor=%b data=%h size=%0d required 1/1/1/0/7",
                          b, rx_op[b], rx_den[b], rx_cor[b], rx_data[b], rx_size[b]);
      end
    end
  endtask

  task automatic test_random;
    int op, size, src, mode, r, nb, w;
    bit den;
    logic [31:0] addr;
    logic [63:0] exp_d;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 0 : (r < 5) ? 1 : (r < 8) ? 4 : (r == 8) ? 5 : 2;
      size = $urandom_range(0, 6);
      if ($urandom_range(0, 15) == 0) size = 7;
      addr = BASE + 32'($urandom_range(0, 8 * DEPTH - 1));
      if ($urandom_range(0, 9) == 0) addr = BASE - 32'($urandom_range(1, 64));
      src  = $urandom_range(0, 7);
      mode = $urandom_range(0, 2);
      den  = m_denied(op, size, addr);
      w    = den ? 0 : m_word(size, addr);
      tx_data.delete(); tx_mask.delete();
      for (int b = 0; b < m_beats(size); b++) begin
        tx_data.push_back({$urandom, $urandom});
        tx_mask.push_back(8'($urandom_range(0, 255)));
      end
      send_req(op, size, src, addr);
      if (op <= 1) m_put(op, size, addr);
      nb = (op == 4 || op == 2) ? m_beats(size) : 1;
      collect(nb, mode);
      n_cmp++;
      if (rx_op.size() != nb || stall_changes != 0) begin
        n_err++; $display("[TB] FAIL rand%0d_beats: got %0d beats %0d stall changes, required %0d beats 0 changes",
                          it, rx_op.size(), stall_changes, nb);
      end
      for (int b = 0; b < rx_op.size(); b++) begin
        exp_d = (op == 4 && !den) ? model_mem[(w + b) % DEPTH] : 64'd0;
        n_cmp++;
        if (rx_op[b] !== 3'((op == 4 || op == 2) ? 1 : (op == 5) ? 2 : 0) || rx_den[b] !== den ||
            rx_data[b] !== exp_d || rx_cor[b] !== ((op == 4 || op == 2) && den) ||
            rx_src[b] !== 3'(src) || rx_size[b] !== 4'(size)) begin
          n_err++; $display("[TB] FAIL rand%0d_beat%0d: op=%0d size=%0d addr=%h got dop=%0d den=%b data=%h cor=%b required den=%b data=%h",
                            it, b, op, size, addr, rx_op[b], rx_den[b], rx_data[b], rx_cor[b], den, exp_d);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int seen;
    int t;
    tx_data.delete(); tx_mask.delete();
    send_req(4, 6, 2, BASE + 32'h40);
    d_ready = 1'b1;
    seen = 0; t = 0;
    while (seen < 3 && t < 100) begin
      @(negedge clock);
      t++;
      if (d_valid) seen++;
    end
    @(negedge clock);
    n_cmp++;
    if (seen != 3 || d_valid !== 1'b1 || d_data !== model_mem[11]) begin
      n_err++; $display("[TB] FAIL midreset_beat3: got seen=%0d valid=%b data=%h required 3/1/%h", seen, d_valid, d_data, model_mem[11]);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (d_valid !== 1'b0 || a_ready !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset_async: got d_valid=%b a_ready=%b required 0/0", d_valid, a_ready);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      n_err++; $display("[TB] FAIL midreset_release: got a_ready=%b d_valid=%b required 1/0", a_ready, d_valid);
    end
    send_req(4, 3, 7, BASE + 32'h10);
    collect(1, 0);
    n_cmp++;
    if (rx_data[0] !== model_mem[2] || rx_den[0] !== 1'b0 || rx_src[0] !== 3'd7) begin
      n_err++; $display("[TB] FAIL midreset_get: got data=%h den=%b src=%0d required %h/0/7", rx_data[0], rx_den[0], rx_src[0], model_mem[2]);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_partial();
    test_burst();
    test_denied();
    test_hint_oversize();
    test_random();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
